seg7_scan_decoder: RTL and testbench

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg7_scan_decoder_if.sv | 19 +
 rtl/seg7_to_bcd.sv | 34 +++
 rtl/seg7_scan_decoder.sv | 155 +++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan decoder.
// Segment patterns are {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] ERR_CODE = 4'hE;

  typedef enum logic {
    SYNC    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  function automatic logic [3:0] onehot(
    input logic [1:0] i
  );
    return 4'b0001 << i;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Sample bus from a multiplexed 7-segment display scanner.
// The scanner side drives; the decoder side observes.
interface seg7_scan_decoder_if;
  logic       load_syn;
  logic [6:0] seg;
  logic [3:0] an;

  modport master (
    output load_syn,
    output seg,
    output an
  );

  modport slave (
    input load_syn,
    input seg,
    input an
  );
endinterface

// File: rtl/seg7_to_bcd.sv
// Combinational segment-pattern to nibble decoder.
// Blank maps to F; anything unrecognised maps to E and flags invalid.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nib_o,
  output logic       inv_o
);

  // Pattern lookup; default covers every undecodable pattern
  always_comb begin
    nib_o = ERR_CODE;
    inv_o = 1'b0;
    case (seg_i)
      SEG_0:     nib_o = 4'd0;
      SEG_1:     nib_o = 4'd1;
      SEG_2:     nib_o = 4'd2;
      SEG_3:     nib_o = 4'd3;
      SEG_4:     nib_o = 4'd4;
      SEG_5:     nib_o = 4'd5;
      SEG_6:     nib_o = 4'd6;
      SEG_7:     nib_o = 4'd7;
      SEG_8:     nib_o = 4'd8;
      SEG_9:     nib_o = 4'd9;
      SEG_BLANK: nib_o = BLANK_CODE;
      default: begin
        nib_o = ERR_CODE;
        inv_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reassembles scanned 7-segment digits into a debounced BCD frame.
// A frame is published only after STABLE_SCANS identical scans.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_SCANS = 2
) (
  input  logic        clk,
  input  logic        rst_syn,
  input  logic        load_syn,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] bcd_out,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        seq_err,
  output logic        locked
);

  localparam logic [2:0] STABLE = 3'(STABLE_SCANS);

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [2:0][3:0] part_q, part_d;
  logic [15:0]     prev_q, prev_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [15:0]     bcd_q, bcd_d;
  logic            fv_q, fv_d;
  logic            serr_q, serr_d;
  logic            qerr_q, qerr_d;

  logic [3:0]  nib;
  logic        inv;
  logic [15:0] frame;
  logic        frame_bad;

  seg7_to_bcd u_dec (
    .seg_i (seg),
    .nib_o (nib),
    .inv_o (inv)
  );

  // Candidate frame uses the freshly decoded digit as d3
  assign frame = {nib, part_q[2], part_q[1], part_q[0]};

  // A frame with any error nibble is never published
  always_comb begin
    frame_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (frame[i*4 +: 4] == ERR_CODE) begin
        frame_bad = 1'b1;
      end
    end
  end

  // Next-state: digit sequencing, frame evaluation, pulses
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    part_d  = part_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    fv_d    = 1'b0;
    serr_d  = 1'b0;
    qerr_d  = 1'b0;
    if (load_syn) begin
      case (state_q)
        SYNC: begin
          if (an == 4'b0001) begin
            part_d[0] = nib;
            idx_d     = 2'd1;
            state_d   = COLLECT;
            serr_d    = inv;
          end
        end
        COLLECT: begin
          if (an == onehot(idx_q)) begin
            serr_d = inv;
            idx_d  = idx_q + 2'd1;
            case (idx_q)
              2'd0: part_d[0] = nib;
              2'd1: part_d[1] = nib;
              2'd2: part_d[2] = nib;
              default: begin
                if (frame_bad) begin
                  cnt_d = 3'd0;
                end else if (frame == prev_q) begin
                  if (cnt_q < STABLE) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_d == STABLE) begin
                      bcd_d = frame;
                      fv_d  = 1'b1;
                    end
                  end
                end else begin
                  prev_d = frame;
                  cnt_d  = 3'd1;
                  if (STABLE == 3'd1) begin
                    bcd_d = frame;
                    fv_d  = 1'b1;
                  end
                end
              end
            endcase
          end else begin
            qerr_d = 1'b1;
            cnt_d  = 3'd0;
            if (an == 4'b0001) begin
              part_d[0] = nib;
              idx_d     = 2'd1;
              serr_d    = inv;
            end else begin
              state_d = SYNC;
              idx_d   = 2'd0;
            end
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst_syn) begin
      state_q <= SYNC;
      idx_q   <= 2'd0;
      part_q  <= '1;
      prev_q  <= 16'hFFFF;
      cnt_q   <= 3'd0;
      bcd_q   <= 16'hFFFF;
      fv_q    <= 1'b0;
      serr_q  <= 1'b0;
      qerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      part_q  <= part_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      fv_q    <= fv_d;
      serr_q  <= serr_d;
      qerr_q  <= qerr_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign frame_valid = fv_q;
  assign seg_err     = serr_q;
  assign seq_err     = qerr_q;
  assign locked      = (state_q == COLLECT);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scans plus random
// samples checked against a queue-based frame model.
module tb_seg7_scan_decoder;

  localparam int S = 2;

  localparam logic [6:0] PAT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  logic        clk = 1'b0;
  logic        rst_syn = 1'b1;
  logic [15:0] bcd_out;
  logic        frame_valid;
  logic        seg_err;
  logic        seq_err;
  logic        locked;

  seg7_scan_decoder_if bus ();

  seg7_scan_decoder #(
    .STABLE_SCANS (S)
  ) dut (
    .clk         (clk),
    .rst_syn     (rst_syn),
    .load_syn    (bus.load_syn),
    .seg         (bus.seg),
    .an          (bus.an),
    .bcd_out     (bcd_out),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .seq_err     (seq_err),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int bad = 0;
  int fv_cnt = 0;
  int base;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_cnt++;
  end

  // Reference model: digits accepted so far in the current frame
  bit          m_locked;
  logic [3:0]  m_q[$];
  logic [15:0] m_prev;
  logic [15:0] m_bcd;
  int          m_cnt;
  bit          e_fv;
  bit          e_serr;
  bit          e_qerr;

  task automatic model_reset();
    m_locked = 1'b0;
    m_q.delete();
    m_prev = 16'hFFFF;
    m_bcd = 16'hFFFF;
    m_cnt = 0;
    e_fv = 1'b0;
    e_serr = 1'b0;
    e_qerr = 1'b0;
  endtask

  task automatic decode(
    input  logic [6:0] s,
    output logic [3:0] n,
    output bit         inv
  );
    n = 4'hE;
    inv = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (s == PAT[i]) begin
        n = 4'(i);
        inv = 1'b0;
      end
    end
    if (s == 7'h00) begin
      n = 4'hF;
      inv = 1'b0;
    end
  endtask

  task automatic model_eval();
    logic [15:0] f;
    bit err;
    f = {m_q[3], m_q[2], m_q[1], m_q[0]};
    err = 1'b0;
    foreach (m_q[i]) if (m_q[i] == 4'hE) err = 1'b1;
    if (err) begin
      m_cnt = 0;
    end else if (f == m_prev) begin
      if (m_cnt < S) begin
        m_cnt++;
        if (m_cnt == S) begin
          m_bcd = f;
          e_fv = 1'b1;
        end
      end
    end else begin
      m_prev = f;
      m_cnt = 1;
      if (S == 1) begin
        m_bcd = f;
        e_fv = 1'b1;
      end
    end
  endtask

  task automatic model_load(
    input logic [3:0] a,
    input logic [6:0] s
  );
    logic [3:0] n;
    bit inv;
    decode(s, n, inv);
    if (!m_locked) begin
      if (a == 4'b0001) begin
        m_q.delete();
        m_q.push_back(n);
        m_locked = 1'b1;
        e_serr = inv;
      end
    end else if (a == 4'(1 << m_q.size())) begin
      m_q.push_back(n);
      e_serr = inv;
      if (m_q.size() == 4) begin
        model_eval();
        m_q.delete();
      end
    end else begin
      e_qerr = 1'b1;
      m_cnt = 0;
      m_q.delete();
      if (a == 4'b0001) begin
        m_q.push_back(n);
        e_serr = inv;
      end else begin
        m_locked = 1'b0;
      end
    end
  endtask

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    vecs++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_bcd"}, bcd_out, m_bcd);
    chk({tag, "_fv"}, 16'(frame_valid), 16'(e_fv));
    chk({tag, "_segerr"}, 16'(seg_err), 16'(e_serr));
    chk({tag, "_seqerr"}, 16'(seq_err), 16'(e_qerr));
    chk({tag, "_locked"}, 16'(locked), 16'(m_locked));
  endtask

  task automatic step(
    input logic       ld,
    input logic [3:0] a,
    input logic [6:0] s
  );
    @(negedge clk);
    rst_syn = 1'b0;
    bus.load_syn = ld;
    bus.an = a;
    bus.seg = s;
    e_fv = 1'b0;
    e_serr = 1'b0;
    e_qerr = 1'b0;
    if (ld) model_load(a, s);
    @(posedge clk);
    #1;
    check_all("step");
  endtask

  task automatic do_reset(input logic ld);
    @(negedge clk);
    rst_syn = 1'b1;
    bus.load_syn = ld;
    bus.an = 4'b0001;
    bus.seg = PAT[4];
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
  endtask

  function automatic logic [6:0] pat(input int d);
    if (d < 10) return PAT[d];
    if (d == 10) return 7'h00;
    return 7'h49;
  endfunction

  task automatic scan4(input int d3, d2, d1, d0);
    step(1'b1, 4'b0001, pat(d0));
    step(1'b1, 4'b0010, pat(d1));
    step(1'b1, 4'b0100, pat(d2));
    step(1'b1, 4'b1000, pat(d3));
  endtask

  initial begin
    logic       ld;
    logic [3:0] a;
    logic [6:0] s;
    int         k;
    int         pos;

    bus.load_syn = 1'b0;
    bus.an = 4'b0000;
    bus.seg = 7'h00;
    model_reset();

    do_reset(1'b0);
    chk("rst_bcd", bcd_out, 16'hFFFF);
    chk("rst_locked", 16'(locked), 16'h0);

    step(1'b0, 4'b0001, PAT[4]);
    step(1'b1, 4'b0010, PAT[3]);
    chk("sync_ignore", 16'(seq_err), 16'h0);

    base = fv_cnt;
    scan4(1, 2, 3, 4);
    chk("r032_early", 16'(frame_valid), 16'h0);
    scan4(1, 2, 3, 4);
    chk("r032_bcd", bcd_out, 16'h1234);
    chk("r032_fv", 16'(frame_valid), 16'h1);

    scan4(1, 2, 3, 4);
    scan4(1, 2, 3, 5);
    chk("r033_pulses", 16'(fv_cnt - base), 16'd1);
    chk("r033_bcd", bcd_out, 16'h1234);

    scan4(10, 2, 3, 4);
    scan4(10, 2, 3, 4);
    chk("r034_bcd", bcd_out, 16'hF234);

    step(1'b1, 4'b0001, PAT[4]);
    step(1'b1, 4'b0010, PAT[3]);
    step(1'b1, 4'b0100, 7'h49);
    chk("r035_segerr", 16'(seg_err), 16'h1);
    step(1'b1, 4'b1000, PAT[1]);
    chk("r035_nopub", 16'(frame_valid), 16'h0);
    chk("r035_hold", bcd_out, 16'hF234);
    scan4(1, 2, 3, 4);
    chk("r035_one", 16'(frame_valid), 16'h0);
    scan4(1, 2, 3, 4);
    chk("r035_two", 16'(frame_valid), 16'h1);
    chk("r035_bcd", bcd_out, 16'h1234);

    step(1'b1, 4'b0001, PAT[4]);
    step(1'b1, 4'b0100, PAT[2]);
    chk("r036_seqerr", 16'(seq_err), 16'h1);
    chk("r036_unlock", 16'(locked), 16'h0);
    step(1'b1, 4'b0001, PAT[4]);
    chk("r036_relock", 16'(locked), 16'h1);

    step(1'b1, 4'b0010, PAT[3]);
    do_reset(1'b1);
    chk("r037_bcd", bcd_out, 16'hFFFF);
    chk("r037_locked", 16'(locked), 16'h0);
    scan4(1, 2, 3, 4);
    chk("r037_one", 16'(frame_valid), 16'h0);
    scan4(1, 2, 3, 4);
    chk("r037_two", 16'(frame_valid), 16'h1);
    chk("r037_bcd", bcd_out, 16'h1234);

    for (int n = 0; n < 600; n++) begin
      ld = ($urandom_range(0, 15) != 0);
      pos = m_locked ? m_q.size() : 0;
      if ($urandom_range(0, 9) == 0) a = 4'($urandom);
      else a = 4'(1 << pos);
      k = $urandom_range(0, 19);
      if (k < 14) s = PAT[pos + 5];
      else if (k < 17) s = PAT[$urandom_range(0, 9)];
      else if (k < 19) s = 7'h00;
      else s = 7'($urandom);
      if ($urandom_range(0, 99) == 0) do_reset(ld);
      else step(ld, a, s);
    end

    step(1'b0, 4'b0000, 7'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule
